// File: rtl/connect6_line_scanner.sv
// connect6_line_scanner: scores every 6-cell window of a streamed Connect6 line and flags six-in-a-row.
// Optional opp_score accumulator is enabled by defining LINE_SCAN_OPP_SCORE_EN.
module connect6_line_scanner #(
   parameter int LINE_LEN = 19,
   parameter int SCORE_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               cell_valid,
   input  logic               cell_own,
   input  logic               cell_opp,
   output logic               cell_ready,
   output logic               busy,
   output logic               done,
   output logic [SCORE_W-1:0] score,
   output logic               win
`ifdef LINE_SCAN_OPP_SCORE_EN
   ,
   output logic [SCORE_W-1:0] opp_score
`endif
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam int AW = (SCORE_W > 11 ? SCORE_W : 11) + 1;
   state_t state, state_nx;
   logic [4:0] own_sr, opp_sr;
   logic [5:0] cnt;
   logic own_in, go, acc, closes;
   logic [2:0] n, m;
   function automatic logic [10:0] weight(input logic [2:0] c);
      return c == 3'd0 ? 11'd0 : 11'd1 << {c - 3'd1, 1'b0};
   endfunction
   // the sum is formed one bit wider than either operand so overflow is visible before clamping
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [10:0] w);
      logic [AW-1:0] s;
      s = AW'(a) + AW'(w);
      return s > AW'({SCORE_W{1'b1}}) ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction
   always_comb begin
      cell_ready = state == LOAD;
      busy       = state == LOAD;
      done       = state == DONE;
      go         = start && state != LOAD;
      acc        = cell_valid && state == LOAD;
      own_in     = cell_own && !cell_opp;
      n          = 3'($countones({own_sr, own_in}));
      m          = 3'($countones({opp_sr, cell_opp}));
      closes     = acc && cnt >= 6'd5;
      state_nx   = go ? LOAD :
                   state == DONE ? IDLE :
                   (acc && cnt == 6'(LINE_LEN - 1)) ? DONE : state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         own_sr <= '0;
         opp_sr <= '0;
         cnt    <= '0;
         score  <= '0;
         win    <= 1'b0;
      end else begin
         state <= state_nx;
         if (go) begin
            own_sr <= '0;
            opp_sr <= '0;
            cnt    <= '0;
            score  <= '0;
            win    <= 1'b0;
         end else if (acc) begin
            own_sr <= {own_sr[3:0], own_in};
            opp_sr <= {opp_sr[3:0], cell_opp};
            cnt    <= cnt + 6'd1;
            if (closes && m == 3'd0) score <= sat_add(score, weight(n));
            if (closes && m == 3'd0 && n == 3'd6) win <= 1'b1;
         end
      end
   end
`ifdef LINE_SCAN_OPP_SCORE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) opp_score <= '0;
      else if (go) opp_score <= '0;
      else if (closes && n == 3'd0) opp_score <= sat_add(opp_score, weight(m));
   end
`endif
endmodule
